if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, drives the synchronous instruction SRAM request and produces `if_to_id_bus` for the decode stage. It is the producer end of the fetch/decode interface and the consumer end of `br_bus`. Decode resolves branches; this block redirects the PC and holds a redirect that arrives while the PC is stalled. SRAM read data returns one cycle after the request, which is exactly when decode has registered `{ce, pc}`.

## Interface
- `RESET_PC`, default 32'hBFC0_0000, first fetched address after reset.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  `StallBus` (6)  pipeline stall vector; bit 0 = PC stop, bit 1 = IF/ID stop; `Stop` = 1.
- `br_bus`  in  `BR_WD` (33)  `{br_e, br_addr[31:0]}` from decode, combinational, same-cycle.
- `if_to_id_bus`  out  `IF_TO_ID_WD` (33)  `{ce, pc[31:0]}` of the instruction currently requested.
- `inst_sram_en`  out  1  fetch request valid.
- `inst_sram_wen`  out  4  constant 4'b0000.
- `inst_sram_addr`  out  32  fetch address, equal to `pc`.
- `inst_sram_wdata`  out  32  constant 0.

## Operation
- State: `pc_reg[31:0]`, `ce_reg`, FSM `{BOOT, RUN, HOLD}`, pending redirect `pend_v`, `pend_addr[31:0]`.
- Reset (async): `pc_reg` = `RESET_PC` − 4, `ce_reg` = 0, FSM = BOOT, `pend_v` = 0, `pend_addr` = 0. All outputs are 0 during reset and in BOOT, including `if_to_id_bus`.
- `next_pc` priority: `br_e` → `br_addr`; else `pend_v` → `pend_addr`; else `pc_reg` + 4 (modulo 2^32, wraps FFFF_FFFC→0000_0000).
- Advance condition: `stall[0]` == NoStop. On advance, `pc_reg` <= `next_pc`, `ce_reg` <= 1, `pend_v` <= 0.
- FSM:
  - BOOT → RUN on the first advance.
  - RUN → HOLD when `stall[0]` == Stop.
  - HOLD → RUN on advance.
  - In HOLD, `pc_reg`, `ce_reg`, `inst_sram_addr` and `inst_sram_en` are held, and the SRAM re-reads the same address.
- Redirect capture: a cycle with `br_e` = 1 and `stall[0]` == Stop sets `pend_v` = 1 and `pend_addr` = `br_addr`. A later `br_e` during the same stall overwrites it (last wins).
- Outputs: `inst_sram_en` = `ce_reg`; `inst_sram_addr` = `pc_reg`; `if_to_id_bus` = `{ce_reg, pc_reg}`.
- Branch delay slot: when a branch is in decode, this block already holds the delay-slot PC. The redirect therefore replaces PC+4 of the delay slot, and no flush is generated.
- No alignment checking; `br_addr[1:0]` is passed through unchanged.

## Timing
- Request-to-data latency is 1 cycle. A PC registered at edge N is presented on the SRAM at cycle N and its data appears at cycle N+1.
- Redirect latency: `br_e` sampled at edge N with no stall → `pc_reg` = `br_addr` after edge N.
- First request: `inst_sram_en` rises after the first unstalled edge following reset deassertion, with address `RESET_PC`.
- Stall release with `pend_v` = 1 and no live `br_e` → `pc_reg` = `pend_addr` after that edge, and `pend_v` clears the same edge.
- Live `br_e` and `pend_v` on the same advancing edge → `br_addr` wins and the pending entry is discarded.
- Reset asserted mid-stall or with `pend_v` set → immediate return to reset values with no pending redirect survival.

## Configuration
- `IF_BR_HOLD_EN` defined: pending redirect register and HOLD capture as above.
- `IF_BR_HOLD_EN` undefined:
  - `pend_v`/`pend_addr` are removed and `next_pc` = `br_e` ? `br_addr` : `pc_reg` + 4.
  - A `br_e` seen only while `stall[0]` == Stop is dropped.
  - Correct operation then relies on decode re-asserting `br_e` on the releasing cycle.
  - All other behaviour is identical.

## Test plan
- Reset, no stall → `inst_sram_addr` sequence BFC0_0000, BFC0_0004, BFC0_0008; `ce` = 1 from the first cycle after BOOT; `inst_sram_wen` = 0 throughout.
- `br_e` = 1, `br_addr` = BFC0_0100 pulsed one cycle while `pc` = BFC0_0008 → next `pc` = BFC0_0100, then BFC0_0104.
- `stall[0]` = 1 for 3 cycles at `pc` = BFC0_0010 → `pc` and `inst_sram_en` held at BFC0_0010, then `pc` = BFC0_0014 on release.
- (`IF_BR_HOLD_EN`) during a stall, `br_e` pulses with BFC0_0200 then BFC0_0300, and `br_e` = 0 at release → `pc` = BFC0_0300 after release, and `pend_v` clears. Without the macro → `pc` = `pc` + 4.
- Pending BFC0_0200 plus live `br_e` with BFC0_0400 on the release edge → `pc` = BFC0_0400.
- Async `rst` pulse mid-cycle during HOLD with `pend_v` = 1 → outputs 0 immediately; restart at BFC0_0000 and ignore the old pending redirect.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage of the 5-stage MIPS pipeline.
//
// Owns the PC, issues the synchronous instruction SRAM read and hands
// {ce, pc} to decode. SRAM data returns one cycle after the request, which
// lines up with decode registering if_to_id_bus.
//
// Ports
//   clk              single clock, rising edge
//   rst              asynchronous, active-high reset
//   stall[5:0]       pipeline stall vector; bit 0 stops the PC (1 = stop)
//   br_bus[32:0]     {br_e, br_addr} from decode, same-cycle combinational
//   if_to_id_bus     {ce, pc} of the instruction currently requested
//   inst_sram_en     fetch request valid
//   inst_sram_wen    always 4'b0000 (read-only port)
//   inst_sram_addr   fetch address (= pc)
//   inst_sram_wdata  always 0
//
// Parameter
//   RESET_PC         first fetched address after reset
//
// Optional feature macro: IF_BR_HOLD_EN
//   defined   : a redirect seen while the PC is stalled is captured in a
//               pending register (last one wins) and applied on release.
//   undefined : such a redirect is dropped; decode must re-assert br_e on
//               the releasing cycle.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata
);

  localparam logic STOP = 1'b1;

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_t;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

  br_t        br;
  if_to_id_t  to_id;
  state_t     state;
  logic [31:0] pc_reg;
  logic        ce_reg;
  logic [31:0] next_pc;
  logic        advance;
  logic        out_v;

  // Only the PC-stop bit matters here; the rest of the vector belongs to
  // later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  assign br      = br_t'(br_bus);
  assign advance = (stall[0] != STOP);

`ifdef IF_BR_HOLD_EN
  logic        pend_v;
  logic [31:0] pend_addr;

  // Live redirect beats a pending one; the pending entry is dropped on any
  // advance, so a stale target can never be applied later.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br.br_e)     next_pc = br.br_addr;
    else if (pend_v) next_pc = pend_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v    <= 1'b0;
      pend_addr <= 32'd0;
    end else if (advance) begin
      pend_v    <= 1'b0;
    end else if (br.br_e) begin
      // Several redirects during one stall: the last one is the live one.
      pend_v    <= 1'b1;
      pend_addr <= br.br_addr;
    end
  end
`else
  // Without the hold register a redirect during a stall is simply lost.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br.br_e) next_pc = br.br_addr;
  end
`endif

  // PC / ce / FSM. pc_reg resets to RESET_PC-4 so the first advance lands
  // exactly on RESET_PC through the normal +4 path. The branch-delay slot is
  // already in flight when decode redirects, so no flush is needed here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC - 32'd4;
      ce_reg <= 1'b0;
      state  <= BOOT;
    end else begin
      if (advance) begin
        pc_reg <= next_pc;
        ce_reg <= 1'b1;
      end
      case (state)
        BOOT:    if (advance)  state <= RUN;
        RUN:     if (!advance) state <= HOLD;
        HOLD:    if (advance)  state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  // In BOOT the pre-decremented pc_reg must not leak onto the outputs.
  assign out_v = (state != BOOT);

  assign to_id.ce = ce_reg;
  assign to_id.pc = out_v ? pc_reg : 32'd0;

  assign if_to_id_bus    = to_id;
  assign inst_sram_en    = ce_reg;
  assign inst_sram_addr  = to_id.pc;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;

endmodule
